mdu_ctrl: RTL and testbench

//  Multiply/divide unit controller for the MIPS EXE stage. It owns the HI/LO

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/div_iter.sv | 35 +++
 rtl/mdu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit controller.
package mdu_pkg;

  // Operation encodings carried on req_op.
  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  // One quotient bit per DIV_RUN cycle; the step counter stops at DIV_LAST.
  localparam int         DIV_STEPS = 32;
  localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_LOAD,
    ST_DIV_RUN,
    ST_DIV_FIX
  } mdu_state_e;

  // 32-bit two's-complement negate when en is set; |0x80000000| stays 0x80000000.
  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic en);
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: one quotient bit per step, unsigned operands.
module div_iter (
  input  logic        clk,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        step,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [32:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dsr_q;
  logic [33:0] diff;

  // Trial subtract of the divisor from the remainder shifted left by one dividend bit.
  assign diff = {rem_q, quot_q[31]} - {2'b00, dsr_q};

  // Load operands on start, otherwise shift in one quotient bit per step.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dsr_q  <= divisor;
    end else if (step) begin
      quot_q <= {quot_q[30:0], ~diff[33]};
      rem_q  <= diff[33] ? {rem_q[31:0], quot_q[31]} : diff[32:0];
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: owns HI/LO, sequences multiplier and divider.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        hilo_ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e state, state_d;

  logic               accept;
  logic               is_mul_op;
  logic [2:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic [5:0]         cnt;

  logic [MUL_LAT-1:0] mul_vld;
  logic [63:0]        mul_data [MUL_LAT];
  logic signed [32:0] mul_a, mul_b;
  logic [63:0]        mul_prod;

  logic               a_neg, b_neg;
  logic [31:0]        div_quot, div_rem;
  logic [31:0]        quot_fix, rem_fix;

  logic               hi_we, lo_we;
  logic [31:0]        hi_d, lo_d;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign hilo_ready = !busy;
  assign accept     = req_valid && req_ready && !flush;
  assign is_mul_op  = (req_op == MDU_OP_MULT) || (req_op == MDU_OP_MULTU);

  // 33x33 signed multiply: the extra top bit is the sign for mult, zero for multu.
  assign mul_a    = {(req_op == MDU_OP_MULT) & req_src1[31], req_src1};
  assign mul_b    = {(req_op == MDU_OP_MULT) & req_src2[31], req_src2};
  assign mul_prod = 64'(mul_a) * 64'(mul_b);

  // Sign handling for div; divu passes operands through untouched.
  assign a_neg    = (op_q == MDU_OP_DIV) && a_q[31];
  assign b_neg    = (op_q == MDU_OP_DIV) && b_q[31];
  assign quot_fix = neg_if(div_quot, a_neg ^ b_neg);
  assign rem_fix  = neg_if(div_rem, a_neg);

  div_iter u_div (
    .clk      (clk),
    .start    (state == ST_DIV_LOAD),
    .dividend (neg_if(a_q, a_neg)),
    .divisor  (neg_if(b_q, b_neg)),
    .step     (state == ST_DIV_RUN),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Capture the accepted op so the requester may change its inputs afterwards.
  // NOTE: pure datapath registers carry no reset; control qualifies every use of them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op;
      a_q  <= req_src1;
      b_q  <= req_src2;
    end
  end

  // Divide step counter: cleared while loading, saturates at the last step.
  always_ff @(posedge clk) begin
    if (reset)                                  cnt <= '0;
    else if (state == ST_DIV_LOAD)              cnt <= '0;
    else if (state == ST_DIV_RUN && cnt != DIV_LAST) cnt <= cnt + 6'd1;
  end

  // Multiplier pipeline valid chain; flush or reset discards any product in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mul_vld <= '0;
    end else begin
      mul_vld[0] <= accept && is_mul_op;
      for (int k = 1; k < MUL_LAT; k++) mul_vld[k] <= mul_vld[k-1];
    end
  end

  // Multiplier pipeline data chain.
  always_ff @(posedge clk) begin
    mul_data[0] <= mul_prod;
    for (int k = 1; k < MUL_LAT; k++) mul_data[k] <= mul_data[k-1];
  end

  // Next-state and HI/LO write selection; flush overrides everything.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = '0;
    lo_d    = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            MDU_OP_MULT, MDU_OP_MULTU: state_d = ST_MUL;
            MDU_OP_DIV, MDU_OP_DIVU:   state_d = ST_DIV_LOAD;
            MDU_OP_MTHI: begin hi_we = 1'b1; hi_d = req_src1; end
            MDU_OP_MTLO: begin lo_we = 1'b1; lo_d = req_src1; end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_vld[MUL_LAT-1]) begin
          state_d = ST_IDLE;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_d    = mul_data[MUL_LAT-1][63:32];
          lo_d    = mul_data[MUL_LAT-1][31:0];
        end
      end
      ST_DIV_LOAD: state_d = (b_q == '0) ? ST_IDLE : ST_DIV_RUN;
      ST_DIV_RUN:  if (cnt == DIV_LAST) state_d = ST_DIV_FIX;
      ST_DIV_FIX: begin
        state_d = ST_IDLE;
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_d    = rem_fix;
        lo_d    = quot_fix;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized traffic vs a behavioural model.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI  = 3'd4, OP_MTLO = 3'd5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        clk, reset, req_valid, req_ready, flush, busy, hilo_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, hi, lo;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: architectural HI/LO plus one pending result with a countdown.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left = 0;
  bit          m_wr = 0;
  bit          m_on = 0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .busy       (busy),
    .hilo_ready (hilo_ready),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        m_left = MUL_LAT; m_wr = 1; m_phi = p[63:32]; m_plo = p[31:0];
      end
      OP_MULTU: begin
        p = 64'(a) * 64'(b);
        m_left = MUL_LAT; m_wr = 1; m_phi = p[63:32]; m_plo = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          m_left = 1; m_wr = 0;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          sq = sa / sb;
          sr = sa % sb;
          m_left = DIV_LAT; m_wr = 1; m_plo = sq[31:0]; m_phi = sr[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) begin
          m_left = 1; m_wr = 0;
        end else begin
          m_left = DIV_LAT; m_wr = 1; m_plo = a / b; m_phi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Model advances on the same edge as the DUT, from the same inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_wr = 0; m_on = 1;
    end else if (m_on) begin
      if (m_left > 0) begin
        if (flush) begin
          m_left = 0; m_wr = 0;
        end else begin
          m_left--;
          if (m_left == 0 && m_wr) begin
            m_hi = m_phi; m_lo = m_plo; m_wr = 0;
          end
        end
      end else if (req_valid && !flush) begin
        model_accept(req_op, req_src1, req_src2);
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("hi",         hi,                 m_hi);
      check("lo",         lo,                 m_lo);
      check("busy",       32'(busy),          32'(m_left > 0));
      check("hilo_ready", 32'(hilo_ready),    32'(m_left == 0));
      check("req_ready",  32'(req_ready),     32'(m_left == 0));
    end
  end

  // Present an op and hold it until the cycle it is accepted; returns on the negedge after.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    for (int i = 0; i < 100; i++) begin
      if (req_ready && !flush && !reset) begin
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL issue_timeout: op %0d never accepted within 100 cycles", op);
    req_valid = 1'b0;
  endtask

  // Count busy cycles (and cycles with req_ready low) from the current negedge.
  task automatic wait_idle(input int exp_cycles, input string name);
    int n = 0;
    int nr = 0;
    while (busy === 1'b1 && n < 200) begin
      if (req_ready === 1'b0) nr++;
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({name, "_ready_low"},   32'(nr), 32'(exp_cycles));
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    // Signed multiply of small negative by positive.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(MUL_LAT, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // Unsigned max*max, then mthi leaves lo alone.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(MUL_LAT, "multu");
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    issue(OP_MTHI, 32'h1234, 32'h0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'h0000_0001);
    check("mthi_busy", 32'(busy), 32'd0);

    // Signed divide with a held follow-on request, then the unsigned variant.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd7; req_src2 = 32'd2;
    wait_idle(DIV_LAT, "div");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle(DIV_LAT, "divu");
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // Signed overflow wraps; divide by zero leaves HI/LO untouched.
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(DIV_LAT, "divovf");
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);
    issue(OP_DIV, 32'd5, 32'd0);
    wait_idle(1, "div0");
    check("div0_lo", lo, 32'h8000_0000);
    check("div0_hi", hi, 32'h0);

    // Flush at busy cycle 10 with an mtlo presented alongside.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1; req_op = OP_MTLO; req_src1 = 32'hAA; req_src2 = 32'h0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd1);
    check("flush_lo", lo, 32'h8000_0000);
    check("flush_hi", hi, 32'h0);
    issue(OP_MTLO, 32'hAA, 32'h0);
    check("mtlo_lo", lo, 32'h0000_00AA);
    check("mtlo_hi", hi, 32'h0);
    repeat (DIV_LAT + 4) @(negedge clk);
    check("flush_nolate_lo", lo, 32'h0000_00AA);

    // Reset in the middle of a divide.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    repeat (DIV_LAT + 6) @(negedge clk);
    check("midrst_nolate_hi", hi, 32'h0);
    check("midrst_nolate_lo", lo, 32'h0);

    // Randomized traffic with occasional flush and reset; the model checks every cycle.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if (!req_valid && $urandom_range(0, 1) == 1) begin
        req_valid = 1'b1;
        req_op    = 3'($urandom_range(0, 5));
        req_src1  = rnd();
        req_src2  = rnd();
      end
      acc = req_valid && req_ready && !flush && !reset;
      @(negedge clk);
      if (acc) req_valid = 1'b0;
    end
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0;
    repeat (DIV_LAT + 4) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
